mips_load_store_unit: RTL and testbench
=======================================

# mips_load_store_unit

Multi-cycle load/store initiator between the MIPS datapath and the word-addressed data memory (`mips_data_mem`). It accepts one byte/halfword/word load or store per request and drives the memory's `mem_address`, `write_data`, `sig_mem_read` and `sig_mem_write`. Sub-word stores are performed as read-modify-write. Sub-word load results are returned sign- or zero-extended on a valid/ready response channel.

## Interface
- `MEM_WORDS`, 256: number of 32-bit words implemented in data memory; word index ≥ MEM_WORDS is an error.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_op`  in  4  {store, size/sign}: 0000 LB, 0001 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1011 SW; all other codes are illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified (SB uses [7:0], SH uses [15:0]).
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, illegal op or out-of-range; no memory access performed.
- `mem_address`  out  32  word-aligned address `{req_addr[31:2],2'b00}`.
- `write_data`  out  32  word to memory.
- `sig_mem_read`  out  1  read strobe; memory data is combinational.
- `sig_mem_write`  out  1  write strobe; memory writes on rising edge.
- `read_data`  in  32  memory read word.

## Operation
- Byte order is big-endian. Offset 0 is [31:24], 1 is [23:16], 2 is [15:8], 3 is [7:0]. Halfword offset 0 is [31:16], offset 2 is [15:0].
- States:
  - IDLE → RD: legal load, SB or SH.
  - IDLE → WR: legal SW.
  - IDLE → RESP: error.
  - RD → RESP: load.
  - RD → WR: SB/SH.
  - WR → RESP.
  - RESP → IDLE: on `resp_valid && resp_ready`.
- Accept occurs on a rising edge with `req_valid && req_ready`. Op, address and wdata are registered at accept. Later changes on the `req_*` inputs are ignored.
- Error conditions, checked at accept:
  - LH, LHU or SH with `addr[0]=1`.
  - LW or SW with `addr[1:0]≠0`.
  - Illegal op code.
  - `addr[31:2] ≥ MEM_WORDS`.
- RD state:
  - `sig_mem_read=1` for exactly one cycle.
  - `read_data` is captured into a word register at the closing edge.
- WR state:
  - `sig_mem_write=1` for exactly one cycle.
  - `write_data` = `req_wdata` for SW.
  - For SB/SH, `write_data` = captured word with the addressed lane replaced by `wdata[7:0]`/`[15:0]`.
- `sig_mem_read` and `sig_mem_write` are never high together. Both are 0 in IDLE and RESP.
- `mem_address` is 0 in IDLE and holds the aligned address in RD, WR and RESP.
- `write_data` is 0 outside WR.
- In RESP, `resp_valid`, `resp_rdata` and `resp_err` are stable until the response handshake.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - `req_ready=1`.
  - `resp_valid=0`, `resp_rdata=0`, `resp_err=0`.
  - `mem_address=0`, `write_data=0`.
  - `sig_mem_read=0`, `sig_mem_write=0`.
- Reset during RD or WR drops the strobes at once, and no write commits.
- Timing relative to accept edge N:
  - Load: RD in cycle N+1; `resp_valid` from N+2.
  - SW: WR in N+1; `resp_valid` from N+2.
  - SB/SH: RD in N+1, WR in N+2; `resp_valid` from N+3.
  - Error: `resp_valid` from N+1.
- Minimum request-to-request spacing is 3, 3, 4 and 2 cycles respectively, when `resp_ready` is held high.
- `req_ready` falls in the cycle after accept and returns the cycle after the response handshake.

## Structure
- Package `mips_lsu_pkg` holds the op code localparams (OP_LB … OP_SW), the state encoding (IDLE, RD, WR, RESP) and a function `is_store(op)`.
- Sub-module `mips_lsu_lane` is purely combinational and contains:
  - load extract/extend from (word, offset, op);
  - store merge from (word, offset, op, wdata).
- The top module holds the FSM and registers.

## Test plan
- Memory word 0x10 = 0x11223344; LW 0x10 → `resp_rdata=0x11223344`. `sig_mem_read` high for one cycle with `mem_address=0x10`, and `resp_valid` two cycles after accept.
- Word 0x14 = 0x80FF7F01:
  - LB 0x14 → 0xFFFFFF80.
  - LBU 0x14 → 0x00000080.
  - LH 0x14 → 0xFFFF80FF.
  - LHU 0x14 → 0x000080FF.
  - LH 0x16 → 0x00007F01.
- SB 0x11 with wdata 0x000000AB → word 0x10 becomes 0x11AB3344, via one RD cycle then one WR cycle. SH 0x12 with wdata 0xBEEF → 0x11ABBEEF.
- Each of the following → `resp_err=1`, `resp_rdata=0`, no strobe ever high, memory unchanged:
  - LW 0x12.
  - SH 0x13.
  - LW 0x400 with MEM_WORDS=256.
  - op 0010.
- `resp_ready` held low for 5 cycles after LW → response held stable and `req_ready=0`. A new `req_valid` during the stall is not accepted.
- `reset_n` pulsed low during the WR cycle of SW 0x20 with data 0xDEADBEEF → strobes fall immediately, word 0x20 is unchanged, and `req_ready=1` after release.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store unit: op codes, FSM states and
// small op-decoding helpers.
package mips_lsu_pkg;

    // Op code is {store, unsigned, size[1:0]}; size 00=byte, 01=half, 11=word
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic is_store(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] offset);
        case (op[1:0])
            2'b01:   return offset[0];
            2'b11:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Byte-lane steering for the load/store unit (big-endian): extracts and
// extends sub-word load data, and merges sub-word store data into a word.
module mips_lsu_lane
    import mips_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/halfword and sign- or zero-extend it
    always_comb begin
        byte_sel = 8'h00;
        case (offset_i)
            2'd0: byte_sel = word_i[31:24];
            2'd1: byte_sel = word_i[23:16];
            2'd2: byte_sel = word_i[15:8];
            2'd3: byte_sel = word_i[7:0];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset_i[1] ? word_i[15:0] : word_i[31:16];

        load_o = word_i;
        case (op_i[1:0])
            2'b00:   load_o = op_i[2] ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_o = op_i[2] ? {16'h0000, half_sel}   : {{16{half_sel[15]}}, half_sel};
            default: load_o = word_i;
        endcase
    end

    // Replace the addressed lane of the old word with the store data
    always_comb begin
        store_o = word_i;
        if (op_i[3]) begin
            case (op_i[1:0])
                2'b00: begin
                    case (offset_i)
                        2'd0: store_o[31:24] = wdata_i[7:0];
                        2'd1: store_o[23:16] = wdata_i[7:0];
                        2'd2: store_o[15:8]  = wdata_i[7:0];
                        2'd3: store_o[7:0]   = wdata_i[7:0];
                        default: store_o = word_i;
                    endcase
                end
                2'b01: begin
                    if (offset_i[1]) store_o[15:0]  = wdata_i[15:0];
                    else             store_o[31:16] = wdata_i[15:0];
                end
                default: store_o = wdata_i;
            endcase
        end
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// Multi-cycle load/store initiator towards the word-addressed data memory.
// Sub-word stores are read-modify-write; responses use a valid/ready channel.
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data
);

    lsu_state_e  state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept  = req_valid && (state_q == IDLE);
    assign req_err = !is_legal(req_op)
                   || is_misaligned(req_op, req_addr[1:0])
                   || ({2'b00, req_addr[31:2]} >= MEM_WORDS);

    mips_lsu_lane u_lane (
        .word_i   (word_q),
        .offset_i (addr_q[1:0]),
        .op_i     (op_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .store_o  (merge_data)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Request capture at accept and memory word capture at the end of RD
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state_q == RD) word_q <= read_data;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)              state_d = RESP;
                    else if (req_op == OP_SW) state_d = WR;
                    else                      state_d = RD;
                end
            end
            RD:      state_d = is_store(op_q) ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state and captured request
    always_comb begin
        req_ready     = (state_q == IDLE);
        resp_valid    = (state_q == RESP);
        resp_err      = (state_q == RESP) && err_q;
        resp_rdata    = '0;
        if ((state_q == RESP) && !err_q && !is_store(op_q)) resp_rdata = load_data;
        mem_address   = (state_q == IDLE) ? '0 : {addr_q[31:2], 2'b00};
        sig_mem_read  = (state_q == RD);
        sig_mem_write = (state_q == WR);
        write_data    = (state_q == WR) ? merge_data : '0;
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Self-checking bench for mips_load_store_unit with a behavioural memory
// and a byte-arithmetic reference model.
module tb_mips_load_store_unit;
    import mips_lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] write_data;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] read_data;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always #5 clock = ~clock;

    mips_load_store_unit #(.MEM_WORDS(256)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .write_data    (write_data),
        .sig_mem_read  (sig_mem_read),
        .sig_mem_write (sig_mem_write),
        .read_data     (read_data)
    );

    // Data memory: combinational read, write on rising edge
    assign read_data = (mem_address[31:10] == 22'd0) ? mem[mem_address[9:2]] : 32'h0;
    always @(posedge clock) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (sig_mem_write && mem_address[31:10] == 22'd0) mem[mem_address[9:2]] <= write_data;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [3:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        if (op == OP_LW || op == OP_SW) return 4;
        return 0;
    endfunction

    function automatic logic m_err(input logic [3:0] op, input logic [31:0] addr);
        int sz;
        sz = m_size(op);
        if (sz == 0) return 1'b1;
        if ((addr % sz) != 0) return 1'b1;
        if ((addr / 4) >= 256) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_mask(input int sz);
        return (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [3:0] op);
        int sz;
        int sh;
        logic [31:0] v;
        sz = m_size(op);
        sh = 8 * (4 - sz - int'(addr % 4));
        v  = (word >> sh) & m_mask(sz);
        if ((op == OP_LB || op == OP_LH) && v[8 * sz - 1]) v = v | ~m_mask(sz);
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] word, input logic [31:0] addr,
                                            input logic [3:0] op, input logic [31:0] wd);
        int sz;
        int sh;
        sz = m_size(op);
        sh = 8 * (4 - sz - int'(addr % 4));
        return (word & ~(m_mask(sz) << sh)) | ((wd & m_mask(sz)) << sh);
    endfunction

    // ---------------- every-cycle output monitor ----------------
    logic        p_rst = 1'b0;
    logic        p_valid = 1'b0;
    logic        p_rr = 1'b0;
    logic        p_err = 1'b0;
    logic [31:0] p_rdata = '0;

    always @(negedge clock) begin
        if (reset_n && p_rst) begin
            chk("strobe_excl", {63'd0, sig_mem_read & sig_mem_write}, 64'd0);
            if (!sig_mem_write) chk("wdata_zero", {32'd0, write_data}, 64'd0);
            if (req_ready) begin
                chk("idle_addr", {32'd0, mem_address}, 64'd0);
                chk("idle_outs", {61'd0, sig_mem_read, sig_mem_write, resp_valid}, 64'd0);
            end
            if (p_valid && !p_rr)
                chk("resp_hold", {29'd0, resp_valid, resp_err, req_ready, resp_rdata},
                                 {29'd0, 1'b1, p_err, 1'b0, p_rdata});
        end
        p_rst   = reset_n;
        p_valid = resp_valid && reset_n;
        p_rr    = resp_ready;
        p_err   = resp_err;
        p_rdata = resp_rdata;
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input int idx, input logic [31:0] val);
        pl_idx = idx[7:0];
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge clock); #1;
        pl_en  = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Issue one request, follow it to its response and compare with the model
    task automatic run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input bit has_pin, input logic [31:0] pin, input int stall);
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat, e_rd, e_wr, lat, n_rd, n_wr, idx;
        bit          st, got;
        st      = op[3];
        e_err   = m_err(op, addr);
        idx     = int'(addr[31:2]);
        e_rdata = (e_err || st) ? 32'h0 : m_load(ref_mem[idx], addr, op);
        e_lat   = e_err ? 1 : ((!st || op == OP_SW) ? 2 : 3);
        e_rd    = (!e_err && op != OP_SW) ? 1 : 0;
        e_wr    = (!e_err && st) ? 1 : 0;
        if (!e_err && st) ref_mem[idx] = m_store(ref_mem[idx], addr, op, wd);

        chk("req_ready_pre", {63'd0, req_ready}, 64'd1);
        resp_ready = (stall == 0);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clock); #1;
        req_valid = 1'b0; req_op = OP_SB; req_addr = ~addr; req_wdata = ~wd;
        chk("req_ready_busy", {63'd0, req_ready}, 64'd0);

        lat = 0; n_rd = 0; n_wr = 0; got = 0;
        for (int k = 1; k <= 12 && !got; k++) begin
            if (sig_mem_read) begin
                n_rd++;
                chk("rd_addr", {32'd0, mem_address}, {32'd0, addr[31:2], 2'b00});
            end
            if (sig_mem_write) begin
                n_wr++;
                chk("wr_addr", {32'd0, mem_address}, {32'd0, addr[31:2], 2'b00});
            end
            if (resp_valid) begin
                got = 1; lat = k;
            end else begin
                @(posedge clock); #1;
            end
        end
        chk("resp_timeout", {63'd0, got}, 64'd1);
        chk("latency", 64'(lat), 64'(e_lat));
        chk("rd_cycles", 64'(n_rd), 64'(e_rd));
        chk("wr_cycles", 64'(n_wr), 64'(e_wr));
        chk("rdata", {32'd0, resp_rdata}, {32'd0, e_rdata});
        chk("err", {63'd0, resp_err}, {63'd0, e_err});
        if (has_pin) chk("pinned_rdata", {32'd0, resp_rdata}, {32'd0, pin});

        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h14;
            @(posedge clock); #1;
            chk("stall_valid", {63'd0, resp_valid}, 64'd1);
            chk("stall_ready", {63'd0, req_ready}, 64'd0);
            chk("stall_rdata", {32'd0, resp_rdata}, {32'd0, e_rdata});
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        chk("req_ready_post", {63'd0, req_ready}, 64'd1);
        if (idx < 256) chk("mem_word", {32'd0, mem[idx]}, {32'd0, ref_mem[idx]});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #3;
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_outs", {60'd0, resp_valid, resp_err, sig_mem_read, sig_mem_write}, 64'd0);
        chk("rst_rdata", {32'd0, resp_rdata}, 64'd0);
        chk("rst_addr_wd", {mem_address, write_data}, 64'd0);
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        preload(4, 32'h11223344);
        preload(5, 32'h80FF7F01);
        preload(8, 32'h01020304);

        run(OP_LW,  32'h10, 32'h0, 1, 32'h11223344, 0);
        run(OP_LB,  32'h14, 32'h0, 1, 32'hFFFFFF80, 0);
        run(OP_LBU, 32'h14, 32'h0, 1, 32'h00000080, 0);
        run(OP_LH,  32'h14, 32'h0, 1, 32'hFFFF80FF, 0);
        run(OP_LHU, 32'h14, 32'h0, 1, 32'h000080FF, 0);
        run(OP_LH,  32'h16, 32'h0, 1, 32'h00007F01, 0);
        run(OP_LB,  32'h15, 32'h0, 1, 32'hFFFFFFFF, 0);
        run(OP_LB,  32'h16, 32'h0, 1, 32'h0000007F, 0);
        run(OP_LBU, 32'h17, 32'h0, 1, 32'h00000001, 0);

        run(OP_SB, 32'h11, 32'h000000AB, 1, 32'h0, 0);
        chk("sb_word", {32'd0, mem[4]}, {32'd0, 32'h11AB3344});
        run(OP_SH, 32'h12, 32'h0000BEEF, 1, 32'h0, 0);
        chk("sh_word", {32'd0, mem[4]}, {32'd0, 32'h11ABBEEF});
        run(OP_LW, 32'h10, 32'h0, 1, 32'h11ABBEEF, 0);

        run(OP_LW,    32'h12,  32'h0,        1, 32'h0, 0);
        run(OP_SH,    32'h13,  32'h0000CAFE, 1, 32'h0, 0);
        run(OP_LW,    32'h400, 32'h0,        1, 32'h0, 0);
        run(4'b0010,  32'h10,  32'h0,        1, 32'h0, 0);
        run(OP_SW,    32'h11,  32'h12345678, 1, 32'h0, 0);
        chk("err_mem_unchanged", {32'd0, mem[4]}, {32'd0, 32'h11ABBEEF});

        run(OP_LW, 32'h14, 32'h0, 1, 32'h80FF7F01, 5);

        // Reset pulse during the WR cycle of a word store
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("sw_in_wr", {63'd0, sig_mem_write}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {62'd0, sig_mem_read, sig_mem_write}, 64'd0);
        chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rst_word_kept", {32'd0, mem[8]}, {32'd0, 32'h01020304});
        chk("rst_ready_after", {63'd0, req_ready}, 64'd1);
        run(OP_LW, 32'h20, 32'h0, 1, 32'h01020304, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
